// File: rtl/player_move_ctrl_if.sv
// Bundle of button, map-select, detector and position signals around the
// player move sequencer. The controller uses the master view; the
// surrounding game logic and collision detector use the slave view.
interface player_move_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       map_load;
  logic [1:0] map_sel;
  logic [5:0] det_new_x;
  logic [5:0] det_new_y;
  logic [5:0] det_cur_x;
  logic [5:0] det_cur_y;
  logic [2:0] det_move;
  logic [1:0] det_map;
  logic [5:0] pos_x;
  logic [5:0] pos_y;
  logic       moved;
  logic       blocked;
  logic       busy;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right,
    input  map_load, map_sel,
    input  det_new_x, det_new_y,
    output det_cur_x, det_cur_y, det_move, det_map,
    output pos_x, pos_y, moved, blocked, busy
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right,
    output map_load, map_sel,
    output det_new_x, det_new_y,
    input  det_cur_x, det_cur_y, det_move, det_map,
    input  pos_x, pos_y, moved, blocked, busy
  );
endinterface

// File: rtl/player_move_ctrl.sv
// Player move sequencer: turns held direction buttons into single-step
// move requests, holds each request while the combinational collision
// detector settles, commits its answer, then waits out a cooldown.
module player_move_ctrl #(
  parameter logic [5:0]  START_X       = 6'd1,
  parameter logic [5:0]  START_Y       = 6'd2,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [23:0] MOVE_COOLDOWN = 24'd0
) (
  input  logic                clk,
  input  logic                reset,
  player_move_ctrl_if.master  bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  localparam logic [2:0] MOVE_NONE  = 3'b000;
  localparam logic [2:0] MOVE_UP    = 3'b001;
  localparam logic [2:0] MOVE_LEFT  = 3'b010;
  localparam logic [2:0] MOVE_DOWN  = 3'b011;
  localparam logic [2:0] MOVE_RIGHT = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  settle_cnt_reg;
  logic [23:0] cool_cnt_reg;
  logic [5:0]  pos_x_reg;
  logic [5:0]  pos_y_reg;
  logic [2:0]  det_move_reg;
  logic [1:0]  det_map_reg;
  logic        moved_reg;
  logic        blocked_reg;
  logic        busy_reg;

  logic [2:0]  req_code;
  logic        pos_changes;

  // Fixed button priority: up > down > left > right.
  always_comb begin
    req_code = MOVE_NONE;
    if (bus.btn_up)         req_code = MOVE_UP;
    else if (bus.btn_down)  req_code = MOVE_DOWN;
    else if (bus.btn_left)  req_code = MOVE_LEFT;
    else if (bus.btn_right) req_code = MOVE_RIGHT;
  end

  assign pos_changes = (bus.det_new_x != pos_x_reg) || (bus.det_new_y != pos_y_reg);

  // Sequencer: request, settle, commit, cooldown. Pulses last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= 4'd0;
      cool_cnt_reg   <= 24'd0;
      pos_x_reg      <= START_X;
      pos_y_reg      <= START_Y;
      det_move_reg   <= MOVE_NONE;
      det_map_reg    <= 2'd0;
      moved_reg      <= 1'b0;
      blocked_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      moved_reg   <= 1'b0;
      blocked_reg <= 1'b0;
      if (bus.map_load) begin
        // Re-spawn drops any in-flight move without a pulse.
        state_reg      <= IDLE;
        settle_cnt_reg <= 4'd0;
        cool_cnt_reg   <= 24'd0;
        pos_x_reg      <= START_X;
        pos_y_reg      <= START_Y;
        det_move_reg   <= MOVE_NONE;
        det_map_reg    <= bus.map_sel;
        busy_reg       <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            det_move_reg <= req_code;
            if (req_code != MOVE_NONE) begin
              settle_cnt_reg <= SETTLE_LOAD;
              state_reg      <= ISSUE;
              busy_reg       <= 1'b1;
            end
          end
          ISSUE: begin
            // Request and current position stay frozen while the detector settles.
            if (settle_cnt_reg != 4'd0) begin
              settle_cnt_reg <= settle_cnt_reg - 4'd1;
            end else begin
              pos_x_reg    <= bus.det_new_x;
              pos_y_reg    <= bus.det_new_y;
              moved_reg    <= pos_changes;
              blocked_reg  <= !pos_changes;
              det_move_reg <= MOVE_NONE;
              cool_cnt_reg <= MOVE_COOLDOWN;
              state_reg    <= HOLD;
            end
          end
          HOLD: begin
            if (cool_cnt_reg == 24'd0) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              cool_cnt_reg <= cool_cnt_reg - 24'd1;
            end
          end
          default: begin
            state_reg    <= IDLE;
            det_move_reg <= MOVE_NONE;
            busy_reg     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.det_cur_x = pos_x_reg;
  assign bus.det_cur_y = pos_y_reg;
  assign bus.det_move  = det_move_reg;
  assign bus.det_map   = det_map_reg;
  assign bus.pos_x     = pos_x_reg;
  assign bus.pos_y     = pos_y_reg;
  assign bus.moved     = moved_reg;
  assign bus.blocked   = blocked_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: two instances (default timing and a slow
// settle/cooldown variant) driven by the same buttons, a toy collision
// detector, an elapsed-time reference model and directed literal checks.
module tb_player_move_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       map_load = 1'b0;
  logic [1:0] map_sel = 2'd0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  player_move_ctrl_if ifa ();
  player_move_ctrl_if ifb ();

  player_move_ctrl #(.SETTLE_CYCLES(1), .MOVE_COOLDOWN(24'd0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  player_move_ctrl #(.SETTLE_CYCLES(3), .MOVE_COOLDOWN(24'd5)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  // Toy collision detector: playfield 1..9 on both axes, plus a wall at (3,3) on map 2.
  function automatic logic [11:0] detect(input logic [5:0] x, input logic [5:0] y,
                                         input logic [2:0] mv, input logic [1:0] mp);
    int nx;
    int ny;
    nx = int'(x);
    ny = int'(y);
    case (mv)
      3'd1: ny = ny - 1;
      3'd2: nx = nx - 1;
      3'd3: ny = ny + 1;
      3'd4: nx = nx + 1;
      default: ;
    endcase
    if (nx <= 0 || ny <= 0 || nx >= 10 || ny >= 10 || (mp == 2'd2 && nx == 3 && ny == 3))
      return {x, y};
    return {nx[5:0], ny[5:0]};
  endfunction

  assign ifa.btn_up = btn_up;      assign ifb.btn_up = btn_up;
  assign ifa.btn_down = btn_down;  assign ifb.btn_down = btn_down;
  assign ifa.btn_left = btn_left;  assign ifb.btn_left = btn_left;
  assign ifa.btn_right = btn_right; assign ifb.btn_right = btn_right;
  assign ifa.map_load = map_load;  assign ifb.map_load = map_load;
  assign ifa.map_sel = map_sel;    assign ifb.map_sel = map_sel;
  assign {ifa.det_new_x, ifa.det_new_y} = detect(ifa.det_cur_x, ifa.det_cur_y, ifa.det_move, ifa.det_map);
  assign {ifb.det_new_x, ifb.det_new_y} = detect(ifb.det_cur_x, ifb.det_cur_y, ifb.det_move, ifb.det_map);

  // DUT outputs gathered per instance for the compare process.
  logic [5:0] o_px [2], o_py [2], o_cx [2], o_cy [2];
  logic [2:0] o_mv [2];
  logic [1:0] o_map [2];
  logic       o_moved [2], o_blk [2], o_busy [2];
  assign o_px[0] = ifa.pos_x;  assign o_px[1] = ifb.pos_x;
  assign o_py[0] = ifa.pos_y;  assign o_py[1] = ifb.pos_y;
  assign o_cx[0] = ifa.det_cur_x; assign o_cx[1] = ifb.det_cur_x;
  assign o_cy[0] = ifa.det_cur_y; assign o_cy[1] = ifb.det_cur_y;
  assign o_mv[0] = ifa.det_move; assign o_mv[1] = ifb.det_move;
  assign o_map[0] = ifa.det_map; assign o_map[1] = ifb.det_map;
  assign o_moved[0] = ifa.moved; assign o_moved[1] = ifb.moved;
  assign o_blk[0] = ifa.blocked; assign o_blk[1] = ifb.blocked;
  assign o_busy[0] = ifa.busy;   assign o_busy[1] = ifb.busy;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a step is described by the number of edges elapsed
  // since the request edge; commit happens S edges later, idle after S+C+1.
  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int cool_of(input int i);
    return (i == 0) ? 0 : 5;
  endfunction

  bit         m_valid = 1'b0;
  bit         m_active [2];
  int         m_elapsed [2];
  logic [2:0] m_code [2];
  logic [5:0] m_x [2], m_y [2];
  logic [1:0] m_map [2];
  bit         m_moved [2], m_blk [2];

  always @(posedge clk) begin
    logic [11:0] nxy;
    for (int i = 0; i < 2; i++) begin
      m_moved[i] = 1'b0;
      m_blk[i]   = 1'b0;
      if (reset) begin
        m_active[i] = 1'b0; m_x[i] = 6'd1; m_y[i] = 6'd2; m_map[i] = 2'd0;
      end else if (map_load) begin
        m_active[i] = 1'b0; m_x[i] = 6'd1; m_y[i] = 6'd2; m_map[i] = map_sel;
      end else if (!m_active[i]) begin
        if (btn_up || btn_down || btn_left || btn_right) begin
          m_active[i]  = 1'b1;
          m_elapsed[i] = 0;
          m_code[i] = btn_up ? 3'd1 : btn_down ? 3'd3 : btn_left ? 3'd2 : 3'd4;
        end
      end else begin
        m_elapsed[i]++;
        if (m_elapsed[i] == settle_of(i)) begin
          nxy = detect(m_x[i], m_y[i], m_code[i], m_map[i]);
          if (nxy == {m_x[i], m_y[i]}) m_blk[i] = 1'b1;
          else m_moved[i] = 1'b1;
          {m_x[i], m_y[i]} = nxy;
        end
        if (m_elapsed[i] == settle_of(i) + cool_of(i) + 1) m_active[i] = 1'b0;
      end
    end
    m_valid = 1'b1;
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        string s;
        s = (i == 0) ? "a" : "b";
        check({"model_pos_x_", s}, int'(o_px[i]), int'(m_x[i]));
        check({"model_pos_y_", s}, int'(o_py[i]), int'(m_y[i]));
        check({"model_cur_", s}, int'({o_cx[i], o_cy[i]}), int'({m_x[i], m_y[i]}));
        check({"model_move_", s}, int'(o_mv[i]),
              (m_active[i] && m_elapsed[i] < settle_of(i)) ? int'(m_code[i]) : 0);
        check({"model_map_", s}, int'(o_map[i]), int'(m_map[i]));
        check({"model_moved_", s}, int'(o_moved[i]), int'(m_moved[i]));
        check({"model_blocked_", s}, int'(o_blk[i]), int'(m_blk[i]));
        check({"model_busy_", s}, int'(o_busy[i]), int'(m_active[i]));
      end
    end
  end

  // One clock edge; inputs change and literals are read just after the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((ifa.busy || ifb.busy) && guard < 40) begin
      tick();
      guard++;
    end
    check("wait_idle_timeout", int'(ifa.busy || ifb.busy), 0);
    tick();
  endtask

  initial begin
    int commits, busy_low, k, first_idle, second_req, commit_k;

    // 1: reset and free move
    tick(2);
    check("reset_pos_x", int'(ifa.pos_x), 1);
    check("reset_pos_y", int'(ifa.pos_y), 2);
    check("reset_move", int'(ifa.det_move), 0);
    check("reset_busy", int'(ifb.busy), 0);
    reset = 1'b0;
    tick();
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    check("free_req_move", int'(ifa.det_move), 4);
    tick();
    check("free_pos_x", int'(ifa.pos_x), 2);
    check("free_pos_y", int'(ifa.pos_y), 2);
    check("free_moved", int'(ifa.moved), 1);
    wait_idle();

    // 2: blocked move from spawn point
    map_load = 1'b1; map_sel = 2'd0;
    tick();
    map_load = 1'b0;
    btn_left = 1'b1;
    tick();
    btn_left = 1'b0;
    tick();
    check("blk_pulse", int'(ifa.blocked), 1);
    check("blk_moved", int'(ifa.moved), 0);
    check("blk_pos_x", int'(ifa.pos_x), 1);
    tick();
    check("blk_pulse_len", int'(ifa.blocked), 0);
    wait_idle();

    // 3: priority and auto-repeat
    {btn_up, btn_down, btn_left, btn_right} = 4'b1111;
    commits = 0;
    busy_low = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (ifa.moved || ifa.blocked) commits++;
      if (!ifa.busy) busy_low++;
      if (ifa.det_move != 3'd0) check("prio_code", int'(ifa.det_move), 1);
    end
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    check("hold_commits", commits, 3);
    check("hold_busy_low", busy_low, 3);
    wait_idle();

    // 4: settle and cooldown on the slow instance, button held
    btn_down = 1'b1;
    tick();
    check("slow_req_move", int'(ifb.det_move), 3);
    first_idle = -1; second_req = -1; commit_k = -1;
    for (k = 1; k <= 14; k++) begin
      tick();
      if (k < 3) check("slow_move_stable", int'(ifb.det_move), 3);
      if (commit_k < 0 && (ifb.moved || ifb.blocked)) commit_k = k;
      if (first_idle < 0 && !ifb.busy) first_idle = k;
      if (first_idle >= 0 && second_req < 0 && ifb.det_move != 3'd0) second_req = k;
    end
    btn_down = 1'b0;
    check("slow_commit_edge", commit_k, 3);
    check("slow_busy_len", first_idle, 9);
    check("slow_next_req", second_req, 10);
    wait_idle();

    // 5: map_load mid-move (commit edge on a, ISSUE on b)
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    map_load = 1'b1; map_sel = 2'b10;
    tick();
    map_load = 1'b0;
    check("ml_pos_x", int'(ifb.pos_x), 1);
    check("ml_pos_y", int'(ifb.pos_y), 2);
    check("ml_map", int'(ifb.det_map), 2);
    check("ml_pulse_a", int'(ifa.moved || ifa.blocked), 0);
    check("ml_busy_b", int'(ifb.busy), 0);
    check("ml_pos_a", int'({ifa.pos_x, ifa.pos_y}), int'({6'd1, 6'd2}));
    wait_idle();

    // 6: reset during HOLD of the slow instance (cool_cnt at 3)
    btn_down = 1'b1;
    tick(6);
    check("pre_rst_busy", int'(ifb.busy), 1);
    reset = 1'b1;
    tick();
    check("rst_busy", int'(ifb.busy), 0);
    check("rst_pos", int'({ifb.pos_x, ifb.pos_y}), int'({6'd1, 6'd2}));
    check("rst_map", int'(ifb.det_map), 0);
    check("rst_pulse", int'(ifb.moved || ifb.blocked), 0);
    reset = 1'b0;
    tick();
    check("post_rst_move", int'(ifb.det_move), 3);
    check("post_rst_busy", int'(ifb.busy), 1);
    btn_down = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Sequencer that owns the player's grid position and drives the combinational `collision_detector`. It turns held direction buttons into one single-step move request at a time. It holds the request stable while the detector settles, commits the detector's answer into the position registers, and then enforces a cooldown before the next step. It sits between the button/input logic and the renderer. All other game logic reads the player position from this block.

## Interface
Parameters:
- `START_X`, default 6'd1: x position loaded on reset and on `map_load`.
- `START_Y`, default 6'd2: y position loaded on reset and on `map_load`.
- `SETTLE_CYCLES`, default 1: cycles the move request is held before commit. Legal range 1..15.
- `MOVE_COOLDOWN`, default 24'd0: extra idle cycles after each commit. Width 24.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: level direction requests, already synchronised.
- `map_load` in 1: one-cycle pulse. Selects a new map and re-spawns the player.
- `map_sel` in 2: map index, sampled only when `map_load` is high.
- `det_new_x`, `det_new_y` in 6 each: collision detector result.
- `det_cur_x`, `det_cur_y` out 6 each: position fed to the detector. Equal to `pos_x`/`pos_y`.
- `det_move` out 3: move code to the detector.
  - 3'b000 none
  - 3'b001 up
  - 3'b010 left
  - 3'b011 down
  - 3'b100 right
- `det_map` out 2: registered map index to the detector.
- `pos_x`, `pos_y` out 6 each: registered player position.
- `moved` out 1: one-cycle pulse on a commit that changed the position.
- `blocked` out 1: one-cycle pulse on a commit that left the position unchanged.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
States are IDLE, ISSUE and HOLD, with two counters: `settle_cnt` (4 bits) and `cool_cnt` (24 bits).

- **Reset** (highest priority):
  - `pos_x`=START_X, `pos_y`=START_Y
  - `det_map`=0, `det_move`=000
  - `moved`=0, `blocked`=0
  - state=IDLE, both counters cleared

- **`map_load`** (next priority, any state):
  - `det_map`<=`map_sel`
  - position <= START
  - `det_move`<=000
  - counters cleared, state<=IDLE
  - no `moved`/`blocked` pulse
  - any in-flight move is dropped

- **IDLE:**
  - If any button is high, pick the direction by fixed priority: up > down > left > right.
  - On that edge: `det_move`<=code, `settle_cnt`<=SETTLE_CYCLES-1, state<=ISSUE.
  - With no button high, stay in IDLE with `det_move`=000.

- **ISSUE:**
  - `det_move` and `det_cur_*` are held constant.
  - Button changes are ignored.
  - If `settle_cnt`≠0, decrement it.
  - If `settle_cnt`=0:
    - `pos_x`<=`det_new_x`, `pos_y`<=`det_new_y`
    - `moved`<=1 if (`det_new_x`,`det_new_y`)≠(`pos_x`,`pos_y`), else `blocked`<=1
    - `det_move`<=000
    - `cool_cnt`<=MOVE_COOLDOWN
    - state<=HOLD

- **HOLD:**
  - If `cool_cnt`=0, state<=IDLE.
  - Otherwise decrement `cool_cnt`.
  - Buttons are ignored.

- **Auto-repeat:** holding a button produces repeated steps, one per move period.
- **Detector output:** the detector result is trusted as-is. There is no range check, and 6-bit values are committed verbatim.

## Timing
- `pos_*`, `det_move`, `det_map`, `moved`, `blocked` and `busy` are all registered outputs.
- **Request:** button sampled in IDLE at edge E0, so `det_move` is valid after E0.
- **Commit:** at edge E0+SETTLE_CYCLES. The new `pos_*` and the `moved`/`blocked` pulse are visible after that edge, for exactly one cycle.
- **Move period** with a button held continuously: SETTLE_CYCLES + MOVE_COOLDOWN + 2 cycles. With defaults this is 3 cycles.
- **`busy`:** rises after E0 and falls after the HOLD→IDLE edge.
- **`map_load` and a button in the same IDLE cycle:** `map_load` wins and no move is issued that cycle. The earliest possible move request is the following cycle.
- **`map_load` on the commit edge:** the position goes to START and no pulse is generated.
- **Reset mid-ISSUE/HOLD:** next cycle matches the reset values, with no pulse.

## Test plan
1. **Reset and free move.** Assert `reset`, then hold `btn_right` for 1 cycle, with the detector model returning (2,2).
   - After reset: `pos`=(1,2), `det_move`=000.
   - After the press: `det_move`=100 one cycle after sampling; `pos`=(2,2) with `moved`=1 two cycles after sampling.
2. **Blocked move.** From (1,2), press `btn_left` with the model returning (1,2).
   - `blocked`=1 for one cycle, `moved`=0, `pos` stays (1,2).
3. **Priority and hold.** Hold all four buttons with MOVE_COOLDOWN=0 for 9 cycles.
   - Exactly 3 commits, all with `det_move`=001.
   - `busy` is low for one cycle between steps.
4. **Settle and cooldown.** Set SETTLE_CYCLES=3 and MOVE_COOLDOWN=5, then press once.
   - `det_move` is stable for 3 cycles.
   - The commit lands on the 3rd edge after E0, and `busy` stays high for 9 cycles.
   - The next step starts no earlier than 10 cycles after E0.
5. **`map_load` mid-move.** Pulse `map_load` with `map_sel`=2'b10 during ISSUE.
   - `pos`=(1,2), `det_map`=10, no `moved`/`blocked` pulse.
   - State is IDLE on the next cycle.
6. **Reset mid-HOLD.** Assert `reset` with `cool_cnt`=3.
   - All outputs reach their reset values the following cycle.
   - A held button issues a move one cycle after `reset` deasserts.
